ifetch_hit_stage: RTL and testbench
===================================

Name: ifetch_hit_stage

Overview:
- Second instruction-fetch pipeline stage, directly downstream of the ifetch tag stage.
- Consumes the tag stage's per-way tags and valid bits, translated PC and TLB status. Resolves hit or miss per way and drives the L1I data-array read.
- Emits the fetched instruction or a fault to decode. Produces the miss, near-miss and LRU-update signals that feed back into the tag stage.
- Tracks outstanding line misses, so a second thread missing on an in-flight line does not issue a duplicate L2 request.

Parameters:
- WAYS, 4, L1I associativity.
- SETS, 64, L1I sets; 64-byte lines.
- TAG_WIDTH, 20, physical tag width; equals 32-6-log2(SETS).
- THREADS, 4, hardware threads per core; also the number of pending-miss entries.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ift_instruction_requested  in  1  tag-stage fetch valid.
- ift_pc_paddr  in  32  physical PC.
- ift_pc_vaddr  in  32  virtual PC.
- ift_thread_idx  in  log2(THREADS)  fetching thread.
- ift_tlb_hit  in  1  translation found.
- ift_tlb_present  in  1  page present.
- ift_tlb_executable  in  1  page executable.
- ift_tag  in  WAYS*TAG_WIDTH  per-way tags, way 0 in the LSBs.
- ift_valid  in  WAYS  per-way valid bits.
- l2i_itag_update_en  in  WAYS  fill, one-hot way.
- l2i_itag_update_set  in  log2(SETS)  fill set.
- l2i_itag_update_tag  in  TAG_WIDTH  fill tag.
- wb_rollback_en  in  1  rollback.
- wb_rollback_thread_idx  in  log2(THREADS)  rolled-back thread.
- ifd_data_read_en  out  1  L1I data-array read strobe.
- ifd_data_read_addr  out  log2(SETS*WAYS*16)  data-array word index, formed as {way,set,word}.
- l1i_read_data  in  32  data-array word, returned one cycle after the read.
- ifd_instruction_valid  out  1  instruction (or fault) valid to decode.
- ifd_instruction  out  32  fetched word.
- ifd_pc  out  32  virtual PC of the fetched word.
- ifd_thread_idx  out  log2(THREADS)  thread of the fetched word.
- ifd_tlb_miss  out  1  TLB-miss fault.
- ifd_page_fault  out  1  page-not-present fault.
- ifd_executable_fault  out  1  no-execute fault.
- ifd_cache_miss  out  1  miss; suspends the thread.
- ifd_near_miss  out  1  miss resolved by a fill in the same cycle.
- ifd_cache_miss_thread_idx  out  log2(THREADS)  missing thread.
- ifd_miss_request  out  1  new L2 line request.
- ifd_miss_paddr  out  26  line address, paddr[31:6].
- ifd_update_lru_en  out  1  LRU touch.
- ifd_update_lru_way  out  log2(WAYS)  way touched.

Behaviour:
- Input stage S0 is the cycle the ift_* signals are valid. Every ifd_* output except the data-read port is registered and valid in S1, a latency of 1. ifd_data_read_* is combinational in S0.
- Reset: all registered outputs 0, and all pending-miss entries invalid. Reset mid-miss discards pending entries; no request is re-issued.
- Way match: way w hits iff ift_valid[w] && tag[w]==paddr[31:31-TAG_WIDTH+1]. At most one way may match; a multi-way match is an assertion failure.
- Fault priority, evaluated only when requested:
  - !tlb_hit gives ifd_tlb_miss.
  - else !present gives ifd_page_fault.
  - else !executable gives ifd_executable_fault.
  - A faulting fetch asserts instruction_valid with the fault flag set. It has no cache access, no miss and no LRU touch.
- Hit:
  - S0: data_read_en=1, addr={way, paddr set, paddr[5:2]}.
  - S1: instruction_valid=1, ifd_instruction=l1i_read_data, update_lru_en=1, update_lru_way=hit way.
- Near miss: no way hits, but in the same S0 cycle l2i_itag_update_en!=0 with matching set and tag.
  - S1: ifd_near_miss=1 and instruction_valid=0.
  - ifd_cache_miss=0 and ifd_miss_request=0; the tag stage refetches.
- Miss:
  - S1: ifd_cache_miss=1 and cache_miss_thread_idx=thread.
  - If the line address matches a valid pending entry: ifd_miss_request=0, merged.
  - Otherwise: ifd_miss_request=1, miss_paddr=line, and the line is allocated in the entry indexed by the thread.
- Pending-entry clear: any L2 fill whose {tag,set} equals an entry's line invalidates that entry in the same edge. A fill and a merge to the same line in one cycle count as a near miss; the near-miss rule takes precedence.
- Squash: wb_rollback_en with rollback thread == S0 thread forces every S1 output of that fetch to 0. This includes the miss and the request; no entry is allocated. A rollback of a different thread has no effect.
- Not requested: all S1 outputs 0 and data_read_en=0.

Test Plan:
- Way 2 holds tag 0x00010 valid; fetch paddr 0x00010044 → S1 instruction_valid=1, instruction=data word, lru_en=1, lru_way=2, read addr = {2, set 1, word 1}.
- Fetch paddr 0x2000 with all ways invalid → S1 cache_miss=1, miss_request=1, miss_paddr=0x80. Thread 1 fetches 0x2004 next cycle → cache_miss=1, miss_request=0.
- Fill set 0 tag matching 0x2000 in the same cycle as a missing fetch → near_miss=1, cache_miss=0, miss_request=0.
- tlb_hit=1, present=1, executable=0 → instruction_valid=1, executable_fault=1, lru_en=0, data_read_en=0. tlb_hit=0 → only tlb_miss=1.
- Miss on thread 0 with wb_rollback_en on thread 0 in the same cycle → no cache_miss and no entry allocated. A subsequent miss to the same line → miss_request=1.
- Assert reset (low) while an entry is pending → all outputs 0 and entries cleared. A re-miss to that line → miss_request=1.

Source files
------------

// File: rtl/ifetch_hit_stage_if.sv
// Signal bundle between the ifetch tag stage, L2 fill/rollback sources, the L1I
// data array and decode, as seen by the ifetch hit stage.
interface ifetch_hit_stage_if #(
    parameter int WAYS      = 4,
    parameter int SETS      = 64,
    parameter int TAG_WIDTH = 20,
    parameter int THREADS   = 4
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int SET_W  = $clog2(SETS);
    localparam int THR_W  = $clog2(THREADS);
    localparam int ADDR_W = $clog2(SETS * WAYS * 16);
    localparam int LINE_W = TAG_WIDTH + SET_W;

    logic                      ift_instruction_requested;
    logic [31:0]               ift_pc_paddr;
    logic [31:0]               ift_pc_vaddr;
    logic [THR_W-1:0]          ift_thread_idx;
    logic                      ift_tlb_hit;
    logic                      ift_tlb_present;
    logic                      ift_tlb_executable;
    logic [WAYS*TAG_WIDTH-1:0] ift_tag;
    logic [WAYS-1:0]           ift_valid;
    logic [WAYS-1:0]           l2i_itag_update_en;
    logic [SET_W-1:0]          l2i_itag_update_set;
    logic [TAG_WIDTH-1:0]      l2i_itag_update_tag;
    logic                      wb_rollback_en;
    logic [THR_W-1:0]          wb_rollback_thread_idx;
    logic                      ifd_data_read_en;
    logic [ADDR_W-1:0]         ifd_data_read_addr;
    logic [31:0]               l1i_read_data;
    logic                      ifd_instruction_valid;
    logic [31:0]               ifd_instruction;
    logic [31:0]               ifd_pc;
    logic [THR_W-1:0]          ifd_thread_idx;
    logic                      ifd_tlb_miss;
    logic                      ifd_page_fault;
    logic                      ifd_executable_fault;
    logic                      ifd_cache_miss;
    logic                      ifd_near_miss;
    logic [THR_W-1:0]          ifd_cache_miss_thread_idx;
    logic                      ifd_miss_request;
    logic [LINE_W-1:0]         ifd_miss_paddr;
    logic                      ifd_update_lru_en;
    logic [WAY_W-1:0]          ifd_update_lru_way;

    modport master (
        output ift_instruction_requested, ift_pc_paddr, ift_pc_vaddr, ift_thread_idx,
               ift_tlb_hit, ift_tlb_present, ift_tlb_executable, ift_tag, ift_valid,
               l2i_itag_update_en, l2i_itag_update_set, l2i_itag_update_tag,
               wb_rollback_en, wb_rollback_thread_idx, l1i_read_data,
        input  ifd_data_read_en, ifd_data_read_addr, ifd_instruction_valid,
               ifd_instruction, ifd_pc, ifd_thread_idx, ifd_tlb_miss, ifd_page_fault,
               ifd_executable_fault, ifd_cache_miss, ifd_near_miss,
               ifd_cache_miss_thread_idx, ifd_miss_request, ifd_miss_paddr,
               ifd_update_lru_en, ifd_update_lru_way
    );

    modport slave (
        input  ift_instruction_requested, ift_pc_paddr, ift_pc_vaddr, ift_thread_idx,
               ift_tlb_hit, ift_tlb_present, ift_tlb_executable, ift_tag, ift_valid,
               l2i_itag_update_en, l2i_itag_update_set, l2i_itag_update_tag,
               wb_rollback_en, wb_rollback_thread_idx, l1i_read_data,
        output ifd_data_read_en, ifd_data_read_addr, ifd_instruction_valid,
               ifd_instruction, ifd_pc, ifd_thread_idx, ifd_tlb_miss, ifd_page_fault,
               ifd_executable_fault, ifd_cache_miss, ifd_near_miss,
               ifd_cache_miss_thread_idx, ifd_miss_request, ifd_miss_paddr,
               ifd_update_lru_en, ifd_update_lru_way
    );
endinterface

// File: rtl/ifetch_hit_stage.sv
// Instruction-fetch hit stage: way match, fault resolution, L1I data read and
// pending-miss tracking so concurrent misses to one line issue a single L2 request.
module ifetch_hit_stage #(
    parameter int WAYS      = 4,
    parameter int SETS      = 64,
    parameter int TAG_WIDTH = 20,
    parameter int THREADS   = 4
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_hit_stage_if.slave bus
);
    localparam int WAY_W   = $clog2(WAYS);
    localparam int SET_W   = $clog2(SETS);
    localparam int THR_W   = $clog2(THREADS);
    localparam int LINE_W  = TAG_WIDTH + SET_W;
    localparam int TAG_LSB = 32 - TAG_WIDTH;

    logic [TAG_WIDTH-1:0] w_req_tag_p0;
    logic [SET_W-1:0]     w_set_p0;
    logic [3:0]           w_word_p0;
    logic [LINE_W-1:0]    w_line_p0;
    logic [LINE_W-1:0]    w_fill_line_p0;
    logic [WAYS-1:0]      w_way_hit_p0;
    logic [WAY_W-1:0]     w_hit_way_p0;
    logic                 w_hit_p0;
    logic                 w_fill_p0;
    logic                 w_near_p0;
    logic                 w_pend_hit_p0;
    logic                 w_live_p0;
    logic                 w_fault_p0;
    logic                 w_do_hit_p0;
    logic                 w_do_miss_p0;
    logic                 w_alloc_p0;
    logic                 w_unused_p0;

    logic                 r_vld_p1;
    logic                 r_hit_p1;
    logic [WAY_W-1:0]     r_lru_way_p1;
    logic [31:0]          r_pc_p1;
    logic [THR_W-1:0]     r_thread_p1;
    logic                 r_tlb_miss_p1;
    logic                 r_page_fault_p1;
    logic                 r_exec_fault_p1;
    logic                 r_miss_p1;
    logic                 r_near_p1;
    logic [THR_W-1:0]     r_miss_thread_p1;
    logic                 r_miss_req_p1;
    logic [LINE_W-1:0]    r_miss_line_p1;

    logic [THREADS-1:0]   r_pend_vld;
    logic [LINE_W-1:0]    r_pend_line [THREADS];

    // ---- S0: decode address, match ways, resolve fault / hit / near miss / merge
    assign w_req_tag_p0   = bus.ift_pc_paddr[31:TAG_LSB];
    assign w_set_p0       = bus.ift_pc_paddr[6 +: SET_W];
    assign w_word_p0      = bus.ift_pc_paddr[5:2];
    assign w_line_p0      = {w_req_tag_p0, w_set_p0};
    assign w_fill_line_p0 = {bus.l2i_itag_update_tag, bus.l2i_itag_update_set};
    assign w_unused_p0    = ^bus.ift_pc_paddr[1:0];

    always_comb begin
        w_way_hit_p0 = '0;
        w_hit_way_p0 = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_way_hit_p0[w] = bus.ift_valid[w] &&
                              (bus.ift_tag[w*TAG_WIDTH +: TAG_WIDTH] == w_req_tag_p0);
            if (w_way_hit_p0[w])
                w_hit_way_p0 = w[WAY_W-1:0];
        end
    end

    always_comb begin
        w_pend_hit_p0 = 1'b0;
        for (int e = 0; e < THREADS; e++)
            if (r_pend_vld[e] && (r_pend_line[e] == w_line_p0))
                w_pend_hit_p0 = 1'b1;
    end

    assign w_hit_p0     = |w_way_hit_p0;
    assign w_fill_p0    = |bus.l2i_itag_update_en;
    assign w_near_p0    = !w_hit_p0 && w_fill_p0 && (w_fill_line_p0 == w_line_p0);
    assign w_fault_p0   = !bus.ift_tlb_hit || !bus.ift_tlb_present || !bus.ift_tlb_executable;
    // A rollback of the fetching thread kills everything it would produce in S1.
    assign w_live_p0    = bus.ift_instruction_requested &&
                          !(bus.wb_rollback_en && (bus.wb_rollback_thread_idx == bus.ift_thread_idx));
    assign w_do_hit_p0  = w_live_p0 && !w_fault_p0 && w_hit_p0;
    assign w_do_miss_p0 = w_live_p0 && !w_fault_p0 && !w_hit_p0 && !w_near_p0;
    assign w_alloc_p0   = w_do_miss_p0 && !w_pend_hit_p0;

    assign bus.ifd_data_read_en   = bus.ift_instruction_requested && !w_fault_p0 && w_hit_p0;
    assign bus.ifd_data_read_addr = {w_hit_way_p0, w_set_p0, w_word_p0};

    assert property (@(posedge clk) disable iff (!reset)
        bus.ift_instruction_requested |-> $onehot0(w_way_hit_p0));

    // ---- S0 -> S1 register boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p1         <= 1'b0;
            r_hit_p1         <= 1'b0;
            r_lru_way_p1     <= '0;
            r_pc_p1          <= '0;
            r_thread_p1      <= '0;
            r_tlb_miss_p1    <= 1'b0;
            r_page_fault_p1  <= 1'b0;
            r_exec_fault_p1  <= 1'b0;
            r_miss_p1        <= 1'b0;
            r_near_p1        <= 1'b0;
            r_miss_thread_p1 <= '0;
            r_miss_req_p1    <= 1'b0;
            r_miss_line_p1   <= '0;
        end else begin
            r_vld_p1         <= w_live_p0 && (w_fault_p0 || w_hit_p0);
            r_hit_p1         <= w_do_hit_p0;
            r_lru_way_p1     <= w_do_hit_p0 ? w_hit_way_p0 : '0;
            r_pc_p1          <= w_live_p0 ? bus.ift_pc_vaddr : '0;
            r_thread_p1      <= w_live_p0 ? bus.ift_thread_idx : '0;
            r_tlb_miss_p1    <= w_live_p0 && !bus.ift_tlb_hit;
            r_page_fault_p1  <= w_live_p0 && bus.ift_tlb_hit && !bus.ift_tlb_present;
            r_exec_fault_p1  <= w_live_p0 && bus.ift_tlb_hit && bus.ift_tlb_present &&
                                !bus.ift_tlb_executable;
            r_miss_p1        <= w_do_miss_p0;
            r_near_p1        <= w_live_p0 && !w_fault_p0 && w_near_p0;
            r_miss_thread_p1 <= w_do_miss_p0 ? bus.ift_thread_idx : '0;
            r_miss_req_p1    <= w_alloc_p0;
            r_miss_line_p1   <= w_alloc_p0 ? w_line_p0 : '0;
        end
    end

    // Pending-miss valids: fills retire matching lines, new requests claim the thread's slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_vld <= '0;
        end else begin
            for (int e = 0; e < THREADS; e++)
                if (w_fill_p0 && (r_pend_line[e] == w_fill_line_p0))
                    r_pend_vld[e] <= 1'b0;
            if (w_alloc_p0)
                r_pend_vld[bus.ift_thread_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc_p0)
            r_pend_line[bus.ift_thread_idx] <= w_line_p0;
    end

    // ---- S1: registered results to decode; read data arrives from the array this cycle
    assign bus.ifd_instruction_valid     = r_vld_p1;
    assign bus.ifd_instruction           = r_hit_p1 ? bus.l1i_read_data : '0;
    assign bus.ifd_pc                    = r_pc_p1;
    assign bus.ifd_thread_idx            = r_thread_p1;
    assign bus.ifd_tlb_miss              = r_tlb_miss_p1;
    assign bus.ifd_page_fault            = r_page_fault_p1;
    assign bus.ifd_executable_fault      = r_exec_fault_p1;
    assign bus.ifd_cache_miss            = r_miss_p1;
    assign bus.ifd_near_miss             = r_near_p1;
    assign bus.ifd_cache_miss_thread_idx = r_miss_thread_p1;
    assign bus.ifd_miss_request          = r_miss_req_p1;
    assign bus.ifd_miss_paddr            = r_miss_line_p1;
    assign bus.ifd_update_lru_en         = r_hit_p1;
    assign bus.ifd_update_lru_way        = r_lru_way_p1;
endmodule

// File: tb/tb_ifetch_hit_stage.sv
// Directed self-checking bench for ifetch_hit_stage: hits, misses with merge,
// near misses, faults, rollback squash and reset while a miss is pending.
module tb_ifetch_hit_stage;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ifetch_hit_stage_if #(.WAYS(4), .SETS(64), .TAG_WIDTH(20), .THREADS(4)) bus ();

    ifetch_hit_stage #(.WAYS(4), .SETS(64), .TAG_WIDTH(20), .THREADS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // way 2 holds tag 0x00010; second set adds way 0 tag 0x00020
    localparam logic [79:0] TAGS_A = {20'h0, 20'h00010, 20'h0, 20'h0};
    localparam logic [79:0] TAGS_B = {20'h0, 20'h00010, 20'h0, 20'h00020};

    // {valid, tlb_miss, page_fault, exec_fault, cache_miss, near_miss, miss_request, lru_en}
    function automatic logic [7:0] flags();
        return {bus.ifd_instruction_valid, bus.ifd_tlb_miss, bus.ifd_page_fault,
                bus.ifd_executable_fault, bus.ifd_cache_miss, bus.ifd_near_miss,
                bus.ifd_miss_request, bus.ifd_update_lru_en};
    endfunction

    task automatic idle();
        bus.ift_instruction_requested = 1'b0;
        bus.l2i_itag_update_en        = '0;
        bus.wb_rollback_en            = 1'b0;
    endtask

    task automatic set_fetch(input logic [1:0] thr, input logic [31:0] pa,
                             input logic [31:0] va, input logic [3:0] vld,
                             input logic [79:0] tags);
        bus.ift_instruction_requested = 1'b1;
        bus.ift_thread_idx            = thr;
        bus.ift_pc_paddr              = pa;
        bus.ift_pc_vaddr              = va;
        bus.ift_valid                 = vld;
        bus.ift_tag                   = tags;
        bus.ift_tlb_hit               = 1'b1;
        bus.ift_tlb_present           = 1'b1;
        bus.ift_tlb_executable        = 1'b1;
        bus.l2i_itag_update_en        = '0;
        bus.wb_rollback_en            = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_fetch(2'd2, 32'h0001_0044, 32'h4000_0044, 4'b0100, TAGS_A);
        bus.l1i_read_data = 32'hCAFE_F00D;
        step();
        n_checks++;
        if (flags() !== 8'h00) begin
            n_fail++; $display("FAIL reset_flags: got %h expected 00", flags());
        end
        n_checks++;
        if ({bus.ifd_pc, bus.ifd_instruction} !== 64'h0) begin
            n_fail++; $display("FAIL reset_pc_instr: got %h/%h expected 0/0", bus.ifd_pc, bus.ifd_instruction);
        end
        n_checks++;
        if ({bus.ifd_miss_paddr, bus.ifd_update_lru_way, bus.ifd_thread_idx} !== 30'h0) begin
            n_fail++; $display("FAIL reset_fields: got paddr %h way %0d thr %0d expected 0", bus.ifd_miss_paddr, bus.ifd_update_lru_way, bus.ifd_thread_idx);
        end
        idle();
        reset = 1'b1;
        step();
    endtask

    task automatic test_hit();
        set_fetch(2'd2, 32'h0001_0044, 32'h4000_0044, 4'b0100, TAGS_A);
        #1;
        n_checks++;
        if ({bus.ifd_data_read_en, bus.ifd_data_read_addr} !== {1'b1, 12'h811}) begin
            n_fail++; $display("FAIL hit_read: got en %b addr %h expected en 1 addr 811", bus.ifd_data_read_en, bus.ifd_data_read_addr);
        end
        step();
        idle();
        bus.l1i_read_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (flags() !== 8'h81) begin
            n_fail++; $display("FAIL hit_flags: got %h expected 81", flags());
        end
        n_checks++;
        if (bus.ifd_instruction !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL hit_instr: got %h expected deadbeef", bus.ifd_instruction);
        end
        n_checks++;
        if ({bus.ifd_update_lru_way, bus.ifd_pc, bus.ifd_thread_idx} !== {2'd2, 32'h4000_0044, 2'd2}) begin
            n_fail++; $display("FAIL hit_fields: got way %0d pc %h thr %0d expected 2/40000044/2", bus.ifd_update_lru_way, bus.ifd_pc, bus.ifd_thread_idx);
        end
        step();
    endtask

    task automatic test_miss_merge();
        set_fetch(2'd0, 32'h0000_2000, 32'h0000_2000, 4'b0000, TAGS_A);
        #1;
        n_checks++;
        if (bus.ifd_data_read_en !== 1'b0) begin
            n_fail++; $display("FAIL miss_read_en: got %b expected 0", bus.ifd_data_read_en);
        end
        step();
        n_checks++;
        if ({flags(), bus.ifd_miss_paddr, bus.ifd_cache_miss_thread_idx} !== {8'h0A, 26'h80, 2'd0}) begin
            n_fail++; $display("FAIL miss_first: got flags %h paddr %h thr %0d expected 0a/80/0", flags(), bus.ifd_miss_paddr, bus.ifd_cache_miss_thread_idx);
        end
        set_fetch(2'd1, 32'h0000_2004, 32'h0000_2004, 4'b0000, TAGS_A);
        step();
        idle();
        n_checks++;
        if ({flags(), bus.ifd_cache_miss_thread_idx} !== {8'h08, 2'd1}) begin
            n_fail++; $display("FAIL miss_merge: got flags %h thr %0d expected 08/1", flags(), bus.ifd_cache_miss_thread_idx);
        end
        step();
    endtask

    task automatic test_near_miss();
        set_fetch(2'd3, 32'h0000_2000, 32'h0000_2000, 4'b0000, TAGS_A);
        bus.l2i_itag_update_en  = 4'b0001;
        bus.l2i_itag_update_set = 6'd0;
        bus.l2i_itag_update_tag = 20'h00002;
        step();
        idle();
        n_checks++;
        if (flags() !== 8'h04) begin
            n_fail++; $display("FAIL near_flags: got %h expected 04", flags());
        end
        step();
        // the fill retired the pending line, so a fresh miss requests again
        set_fetch(2'd3, 32'h0000_2000, 32'h0000_2000, 4'b0000, TAGS_A);
        step();
        idle();
        n_checks++;
        if ({flags(), bus.ifd_cache_miss_thread_idx} !== {8'h0A, 2'd3}) begin
            n_fail++; $display("FAIL near_refill_req: got flags %h thr %0d expected 0a/3", flags(), bus.ifd_cache_miss_thread_idx);
        end
        step();
    endtask

    task automatic test_faults();
        set_fetch(2'd1, 32'h0001_0044, 32'h0001_0044, 4'b0100, TAGS_A);
        bus.ift_tlb_executable = 1'b0;
        #1;
        n_checks++;
        if (bus.ifd_data_read_en !== 1'b0) begin
            n_fail++; $display("FAIL exec_read_en: got %b expected 0", bus.ifd_data_read_en);
        end
        step();
        n_checks++;
        if (flags() !== 8'h90) begin
            n_fail++; $display("FAIL exec_fault: got %h expected 90", flags());
        end
        set_fetch(2'd1, 32'h0000_5000, 32'h0000_5000, 4'b0000, TAGS_A);
        bus.ift_tlb_hit        = 1'b0;
        bus.ift_tlb_present    = 1'b0;
        bus.ift_tlb_executable = 1'b0;
        step();
        n_checks++;
        if (flags() !== 8'hC0) begin
            n_fail++; $display("FAIL tlb_miss: got %h expected c0", flags());
        end
        set_fetch(2'd1, 32'h0000_5000, 32'h0000_5000, 4'b0000, TAGS_A);
        bus.ift_tlb_present    = 1'b0;
        bus.ift_tlb_executable = 1'b0;
        step();
        idle();
        n_checks++;
        if (flags() !== 8'hA0) begin
            n_fail++; $display("FAIL page_fault: got %h expected a0", flags());
        end
        step();
    endtask

    task automatic test_squash();
        set_fetch(2'd0, 32'h0000_3000, 32'h0000_3000, 4'b0000, TAGS_A);
        bus.wb_rollback_en         = 1'b1;
        bus.wb_rollback_thread_idx = 2'd0;
        step();
        n_checks++;
        if ({flags(), bus.ifd_miss_paddr} !== {8'h00, 26'h0}) begin
            n_fail++; $display("FAIL squash_same: got flags %h paddr %h expected 00/0", flags(), bus.ifd_miss_paddr);
        end
        set_fetch(2'd0, 32'h0000_3000, 32'h0000_3000, 4'b0000, TAGS_A);
        bus.wb_rollback_en         = 1'b1;
        bus.wb_rollback_thread_idx = 2'd2;
        step();
        idle();
        n_checks++;
        if ({flags(), bus.ifd_miss_paddr} !== {8'h0A, 26'hC0}) begin
            n_fail++; $display("FAIL squash_other: got flags %h paddr %h expected 0a/c0", flags(), bus.ifd_miss_paddr);
        end
        step();
    endtask

    task automatic test_reset_mid_miss();
        set_fetch(2'd1, 32'h0000_4000, 32'h0000_4000, 4'b0000, TAGS_A);
        step();
        n_checks++;
        if (flags() !== 8'h0A) begin
            n_fail++; $display("FAIL rst_first_miss: got %h expected 0a", flags());
        end
        set_fetch(2'd2, 32'h0000_4000, 32'h0000_4000, 4'b0000, TAGS_A);
        step();
        idle();
        n_checks++;
        if (flags() !== 8'h08) begin
            n_fail++; $display("FAIL rst_merge: got %h expected 08", flags());
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (flags() !== 8'h00) begin
            n_fail++; $display("FAIL rst_async: got %h expected 00", flags());
        end
        step();
        reset = 1'b1;
        step();
        set_fetch(2'd2, 32'h0000_4000, 32'h0000_4000, 4'b0000, TAGS_A);
        step();
        idle();
        n_checks++;
        if ({flags(), bus.ifd_miss_paddr} !== {8'h0A, 26'h100}) begin
            n_fail++; $display("FAIL rst_remiss: got flags %h paddr %h expected 0a/100", flags(), bus.ifd_miss_paddr);
        end
        step();
    endtask

    task automatic test_back_to_back();
        set_fetch(2'd0, 32'h0001_004C, 32'h0001_004C, 4'b0101, TAGS_B);
        #1;
        n_checks++;
        if ({bus.ifd_data_read_en, bus.ifd_data_read_addr} !== {1'b1, 12'h813}) begin
            n_fail++; $display("FAIL b2b_read0: got en %b addr %h expected 1/813", bus.ifd_data_read_en, bus.ifd_data_read_addr);
        end
        step();
        bus.l1i_read_data = 32'h1111_1111;
        set_fetch(2'd1, 32'h0002_0080, 32'h0002_0080, 4'b0101, TAGS_B);
        #1;
        n_checks++;
        if ({flags(), bus.ifd_instruction, bus.ifd_update_lru_way} !== {8'h81, 32'h1111_1111, 2'd2}) begin
            n_fail++; $display("FAIL b2b_out0: got flags %h instr %h way %0d expected 81/11111111/2", flags(), bus.ifd_instruction, bus.ifd_update_lru_way);
        end
        n_checks++;
        if ({bus.ifd_data_read_en, bus.ifd_data_read_addr} !== {1'b1, 12'h020}) begin
            n_fail++; $display("FAIL b2b_read1: got en %b addr %h expected 1/020", bus.ifd_data_read_en, bus.ifd_data_read_addr);
        end
        step();
        bus.l1i_read_data = 32'h2222_2222;
        idle();
        #1;
        n_checks++;
        if ({flags(), bus.ifd_instruction, bus.ifd_update_lru_way, bus.ifd_thread_idx} !== {8'h81, 32'h2222_2222, 2'd0, 2'd1}) begin
            n_fail++; $display("FAIL b2b_out1: got flags %h instr %h way %0d thr %0d expected 81/22222222/0/1", flags(), bus.ifd_instruction, bus.ifd_update_lru_way, bus.ifd_thread_idx);
        end
        step();
        n_checks++;
        if ({flags(), bus.ifd_instruction} !== {8'h00, 32'h0}) begin
            n_fail++; $display("FAIL b2b_idle: got flags %h instr %h expected 00/0", flags(), bus.ifd_instruction);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.ift_instruction_requested = 1'b0;
        bus.ift_pc_paddr              = '0;
        bus.ift_pc_vaddr              = '0;
        bus.ift_thread_idx            = '0;
        bus.ift_tlb_hit               = 1'b0;
        bus.ift_tlb_present           = 1'b0;
        bus.ift_tlb_executable        = 1'b0;
        bus.ift_tag                   = '0;
        bus.ift_valid                 = '0;
        bus.l2i_itag_update_en        = '0;
        bus.l2i_itag_update_set       = '0;
        bus.l2i_itag_update_tag       = '0;
        bus.wb_rollback_en            = 1'b0;
        bus.wb_rollback_thread_idx    = '0;
        bus.l1i_read_data             = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_hit();
        test_miss_merge();
        test_near_miss();
        test_faults();
        test_squash();
        test_reset_mid_miss();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
